ks_audio_out: RTL and testbench

Sample reader and 1-bit audio output stage for the Karplus-Strong voice. It paces the string by pulsing an advance strobe at a programmable sample rate; the top level drives the string's freeze input with the inverse of this strobe. On each advance it captures the signed string sample, applies a volume shift and converts it to offset binary. It then drives a single audio pin using either PWM or first-order sigma-delta modulation.

---
 rtl/ks_audio_out_pkg.sv | 16 +
 rtl/ks_modulator.sv | 51 +++++
 rtl/ks_audio_out.sv | 76 +++++++
 tb/tb_ks_audio_out.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ks_audio_out_pkg.sv
// Shared constants for the Karplus-Strong audio output stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ks_audio_out_pkg;

   localparam int KS_DATA_WIDTH = 8;
   localparam int KS_DIV_WIDTH  = 16;

   localparam logic [KS_DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(KS_DATA_WIDTH-1){1'b0}}};

   typedef enum logic {
      MODE_PWM = 1'b0,
      MODE_SD  = 1'b1
   } mode_e;

endpackage

// File: rtl/ks_modulator.sv
// 1-bit audio modulator: free-running PWM compare or first-order sigma-delta.
// Latency: audio_o reflects level_i and mode_sd_i one clock after they are presented.
// Backpressure: none; both modulators advance every enabled cycle and clear when disabled.
module ks_modulator
   import ks_audio_out_pkg::*;
#(
   parameter int DATA_WIDTH = KS_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  mode_sd_i,
   input  logic [DATA_WIDTH-1:0] level_i,
   output logic                  audio_o
);

   logic [DATA_WIDTH-1:0] pwm_cnt;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH:0]   sum;
   logic                  audio_nxt;
   mode_e                 mode;

   assign mode = mode_e'(mode_sd_i);
   // The carry out of the accumulator is the sigma-delta bit; its density is level/2^W.
   assign sum  = {1'b0, acc} + {1'b0, level_i};

   always_comb begin
      audio_nxt = 1'b0;
      case (mode)
         MODE_SD:  audio_nxt = sum[DATA_WIDTH];
         default:  audio_nxt = (pwm_cnt < level_i);
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pwm_cnt <= '0;
         acc     <= '0;
         audio_o <= 1'b0;
      end else if (!en_i) begin
         pwm_cnt <= '0;
         acc     <= '0;
         audio_o <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + DATA_WIDTH'(1);
         acc     <= sum[DATA_WIDTH-1:0];
         audio_o <= audio_nxt;
      end
   end

endmodule

// File: rtl/ks_audio_out.sv
// Paces the string, captures and scales its sample to offset binary, drives the audio pin.
// Latency: level_o one clock after the advance_o cycle, audio_o one clock after that.
// Backpressure: none; en_i low silences the output and stops pacing, level_o holds.
module ks_audio_out
   import ks_audio_out_pkg::*;
#(
   parameter int DATA_WIDTH = KS_DATA_WIDTH,
   parameter int DIV_WIDTH  = KS_DIV_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [DIV_WIDTH-1:0]  div_i,
   input  logic                  mode_sd_i,
   input  logic [2:0]            volume_i,
   input  logic [DATA_WIDTH-1:0] sample_i,
   output logic                  advance_o,
   output logic                  sample_tick_o,
   output logic [DATA_WIDTH-1:0] level_o,
   output logic                  audio_o
);

   localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DIV_WIDTH-1:0]         cnt;
   logic [DIV_WIDTH-1:0]         div_eff;
   logic                         tick_w;
   logic                         capture;
   logic signed [DATA_WIDTH-1:0] scaled;
   logic [DATA_WIDTH-1:0]        level_w;

   assign div_eff = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
   // >= rather than == so a divisor lowered mid-period wraps on the next edge.
   assign tick_w  = en_i && (cnt >= div_eff - DIV_WIDTH'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt       <= '0;
         advance_o <= 1'b0;
      end else if (!en_i) begin
         cnt       <= '0;
         advance_o <= 1'b0;
      end else begin
         cnt       <= tick_w ? '0 : cnt + DIV_WIDTH'(1);
         advance_o <= tick_w;
      end
   end

   assign capture = advance_o && en_i;
   assign scaled  = $signed(sample_i) >>> volume_i;
   assign level_w = scaled ^ MID;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         level_o       <= MID;
         sample_tick_o <= 1'b0;
      end else begin
         sample_tick_o <= capture;
         if (capture) begin
            level_o <= level_w;
         end
      end
   end

   ks_modulator #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_modulator (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .mode_sd_i (mode_sd_i),
      .level_i   (level_o),
      .audio_o   (audio_o)
   );

endmodule

// File: tb/tb_ks_audio_out.sv
// Randomized and directed bench for ks_audio_out against a behavioural reference model.
// Inputs change 1ns after each rising edge; outputs are compared 1ns after the edge.
module tb_ks_audio_out;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        en_i;
   logic [15:0] div_i;
   logic        mode_sd_i;
   logic [2:0]  volume_i;
   logic [7:0]  sample_i;
   logic        advance_o;
   logic        sample_tick_o;
   logic [7:0]  level_o;
   logic        audio_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: plain integers.
   int      m_elapsed;   // clocks elapsed in the current sample period
   int      m_pwm;       // enabled clocks since modulator clear, mod 256
   longint  m_total;     // running sum of levels fed to the sigma-delta since clear
   int      m_level;
   bit      m_adv, m_stick, m_audio;

   always #5 clk_i = ~clk_i;

   ks_audio_out dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .div_i         (div_i),
      .mode_sd_i     (mode_sd_i),
      .volume_i      (volume_i),
      .sample_i      (sample_i),
      .advance_o     (advance_o),
      .sample_tick_o (sample_tick_o),
      .level_o       (level_o),
      .audio_o       (audio_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int scaled_level(input logic [7:0] s, input int vol);
      int v;
      v = int'(s);
      if (v > 127) v = v - 256;
      for (int i = 0; i < vol; i++) v = (v < 0) ? -((1 - v) / 2) : v / 2;  // floor(v/2)
      return ((v + 256) % 256) ^ 128;
   endfunction

   task automatic model_reset();
      m_elapsed = 0; m_pwm = 0; m_total = 0; m_level = 128;
      m_adv = 0; m_stick = 0; m_audio = 0;
   endtask

   task automatic model_edge();
      int eff;
      bit tick, carry;
      eff = (int'(div_i) < 2) ? 2 : int'(div_i);
      if (!en_i) begin
         m_elapsed = 0; m_pwm = 0; m_total = 0;
         m_adv = 0; m_stick = 0; m_audio = 0;
      end else begin
         carry   = ((m_total + m_level) / 256) != (m_total / 256);
         m_audio = mode_sd_i ? carry : (m_pwm < m_level);
         m_total = m_total + m_level;
         m_pwm   = (m_pwm + 1) % 256;
         tick    = (m_elapsed + 1 >= eff);
         m_stick = m_adv;
         if (m_adv) m_level = scaled_level(sample_i, int'(volume_i));
         m_adv     = tick;
         m_elapsed = tick ? 0 : m_elapsed + 1;
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      if (rst_i) model_reset(); else model_edge();
      #1;
      check("advance", advance_o, m_adv);
      check("sample_tick", sample_tick_o, m_stick);
      check("level", level_o, m_level);
      check("audio", audio_o, m_audio);
   endtask

   initial begin
      int ones, k, got;
      rst_i = 1'b1; en_i = 1'b1; div_i = 16'd10; mode_sd_i = 1'b0;
      volume_i = 3'd0; sample_i = 8'h25;
      model_reset();
      #1;
      check("rst_async_level", level_o, 32'h80);
      repeat (2) step();
      check("rst_adv", advance_o, 0);
      check("rst_audio", audio_o, 0);
      check("rst_level", level_o, 32'h80);
      rst_i = 1'b0;

      // div 10: pulses on cycles 10, 20, 30 after release, tick one cycle later
      for (int c = 1; c <= 32; c++) begin
         step();
         check("div10_adv", advance_o, (c % 10 == 0) ? 1 : 0);
         check("div10_tick", sample_tick_o, (c % 10 == 1 && c > 1) ? 1 : 0);
         if (c <= 10) check("pre_capture_level", level_o, 32'h80);
      end
      check("first_capture", level_o, 32'hA5);

      // level 0xC0: PWM 192/256, sigma-delta 3/4
      div_i = 16'd4; sample_i = 8'h40;
      k = 0;
      while (!sample_tick_o && k < 20) begin step(); k++; end
      check("c0_tick_seen", sample_tick_o, 1);
      check("c0_level", level_o, 32'hC0);
      repeat (2) step();
      ones = 0;
      for (int i = 0; i < 256; i++) begin step(); ones += audio_o; end
      check("pwm_density", ones, 192);
      mode_sd_i = 1'b1;
      step();
      ones = 0;
      for (int i = 0; i < 256; i++) begin step(); ones += audio_o; end
      check("sd_density", ones, 192);

      // volume shifts
      volume_i = 3'd2; sample_i = 8'h80;
      k = 0;
      do begin step(); k++; end while (!sample_tick_o && k < 20);
      check("vol2_neg", level_o, 32'h60);
      volume_i = 3'd7; sample_i = 8'h7F;
      k = 0;
      do begin step(); k++; end while (!sample_tick_o && k < 20);
      check("vol7_pos", level_o, 32'h80);

      // divisor lowered from 100 to 5 mid-period
      div_i = 16'd100; sample_i = 8'h33; volume_i = 3'd0;
      k = 0;
      do begin step(); k++; end while (m_elapsed != 50 && k < 250);
      check("reach_cnt50", m_elapsed, 50);
      div_i = 16'd5;
      step();
      check("lower_div_adv", advance_o, 1);
      repeat (4) step();
      step();
      check("div5_period", advance_o, 1);
      div_i = 16'd0;
      ones = 0;
      for (int i = 0; i < 10; i++) begin step(); ones += advance_o; end
      check("div0_rate", ones, 5);

      // enable dropped mid-period, then restored
      div_i = 16'd8; mode_sd_i = 1'b0; sample_i = 8'h70;
      k = 0;
      do begin step(); k++; end while (!(m_elapsed == 3 && !m_adv && m_level > 0) && k < 50);
      got = m_level;
      en_i = 1'b0;
      step();
      check("dis_audio", audio_o, 0);
      check("dis_adv", advance_o, 0);
      check("dis_level_hold", level_o, got);
      repeat (3) step();
      en_i = 1'b1;
      k = 0;
      do begin step(); k++; end while (!advance_o && k < 50);
      check("reenable_latency", k, 8);

      // randomized run
      for (int i = 0; i < 3000; i++) begin
         sample_i = 8'($urandom);
         if ($urandom_range(0, 19) == 0) volume_i = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) div_i = 16'($urandom_range(0, 12));
         if ($urandom_range(0, 29) == 0) mode_sd_i = ~mode_sd_i;
         if ($urandom_range(0, 49) == 0) en_i = ~en_i;
         step();
      end

      // asynchronous reset between edges during sigma-delta output
      en_i = 1'b1; div_i = 16'd4; sample_i = 8'h40; volume_i = 3'd0; mode_sd_i = 1'b1;
      repeat (20) step();
      check("pre_rst_level", level_o, 32'hC0);
      #2 rst_i = 1'b1;
      model_reset();
      #1;
      check("arst_audio", audio_o, 0);
      check("arst_adv", advance_o, 0);
      check("arst_tick", sample_tick_o, 0);
      check("arst_level", level_o, 32'h80);
      step();
      rst_i = 1'b0;
      repeat (40) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
